imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter MEMORY_SIZE, default 32, giving the instruction memory depth in 32-bit words.
REQ-002 The block SHALL have parameter CW, default 6, giving the word-count width; CW SHALL satisfy 2**CW > MEMORY_SIZE.
REQ-003 Port clk  input  1  is the single clock; all state changes occur on its rising edge.
REQ-004 Port rst_n  input  1  is the reset: asynchronous, active-low.
REQ-005 Port start  input  1  is a one-cycle request to begin a load session.
REQ-006 Port num_words  input  CW  is the number of words to load; it is sampled only on an accepted start.
REQ-007 Port abort  input  1  is a synchronous cancel of the current session.
REQ-008 Port byte_valid  input  1  indicates that byte_data holds a stream byte.
REQ-009 Port byte_data  input  8  is the stream byte.
REQ-010 Port byte_ready  output  1  indicates the loader accepts a byte this cycle.
REQ-011 Port mem_we  output  1  is the instruction-memory write strobe.
REQ-012 Port mem_addr  output  32  is the byte address of the write, always word-aligned.
REQ-013 Port mem_wdata  output  32  is the write data.
REQ-014 Port busy  output  1  is high while a session is in progress.
REQ-015 Port cpu_hold  output  1  holds the CPU (PC and fetch) while memory is being rewritten.
REQ-016 Port done  output  1  indicates the last session completed.
REQ-017 Port error  output  1  indicates the last start was rejected.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, WRITE and DONE.
REQ-019 start SHALL be accepted only in IDLE or DONE; start in LOAD or WRITE is ignored.
REQ-020 An accepted start SHALL clear done, error, byte_idx and word_idx, and latch num_words.
REQ-021 An accepted start with num_words==0 SHALL go to DONE with no writes.
REQ-022 An accepted start with num_words>MEMORY_SIZE SHALL go to DONE with error=1 and no writes.
REQ-023 Otherwise an accepted start SHALL go to LOAD.
REQ-024 In LOAD: byte_ready=1, busy=1, cpu_hold=1.
- A byte is accepted only on a cycle with byte_valid&&byte_ready.
- byte_valid without byte_ready SHALL have no effect.
REQ-025 Byte assembly SHALL be little-endian: accepted byte k of a word (k=0..3, a 2-bit counter) goes to bits [8k+7:8k].
REQ-026 On the 4th accepted byte the FSM SHALL go to WRITE.
REQ-027 WRITE SHALL last exactly one cycle with:
- mem_we=1, mem_wdata = assembled word, mem_addr = {word_idx,2'b00} zero-extended to 32 bits;
- byte_ready=0.
REQ-028 mem_we SHALL be 0 in every other state; mem_addr and mem_wdata hold their last values.
REQ-029 After WRITE:
- if word_idx==num_words-1, go to DONE;
- else increment word_idx, reset byte_idx to 0 and return to LOAD.
REQ-030 Latency from the 4th accepted byte to mem_we=1 SHALL be exactly 1 cycle.
REQ-031 Maximum throughput SHALL be one word per 5 cycles.
REQ-032 In DONE: done=1, busy=0, cpu_hold=0, byte_ready=0; DONE persists until an accepted start.
REQ-033 abort in LOAD SHALL go to IDLE next cycle, discard the partial word and perform no write; done stays 0.
REQ-034 abort in WRITE SHALL let the write complete, then go to IDLE.
REQ-035 abort in IDLE or DONE SHALL have no effect.
REQ-036 When abort and start are both high, abort SHALL have priority.
REQ-037 In IDLE: busy=0, cpu_hold=0, byte_ready=0.

Reset
REQ-038 rst_n low SHALL immediately force state=IDLE, byte_idx=0, word_idx=0, and all outputs to 0 (mem_addr and mem_wdata = 32'h0).
REQ-039 Reset mid-session SHALL discard all progress; no mem_we pulse SHALL occur while rst_n is low.
REQ-040 After rst_n rises, the first accepted start SHALL be possible on the next rising edge.

Verification
REQ-041 The bench SHALL cover single word: start with num_words=1, stream 13,05,50,00 -> one mem_we with mem_addr=0 and mem_wdata=32'h00500513, then done=1 and cpu_hold=0.
REQ-042 The bench SHALL cover three words with random byte_valid gaps -> writes at addresses 0, 4 and 8 with correct data, exactly 3 mem_we pulses, and byte_ready=0 in each WRITE cycle.
REQ-043 The bench SHALL cover boundaries:
- num_words=0 -> done=1 and error=0 with no writes;
- num_words=33 -> done=1 and error=1 with no writes;
- num_words=32 -> last write at mem_addr=124.
REQ-044 The bench SHALL cover abort after 2 bytes of word 1 -> IDLE, no write for word 1; a new start restarts at mem_addr=0.
REQ-045 The bench SHALL cover start asserted during LOAD -> ignored, with no change to num_words or indices.
REQ-046 The bench SHALL cover rst_n pulled low mid-LOAD -> outputs 0 asynchronously and no spurious mem_we.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit words and writes
// them to consecutive word addresses of an instruction memory, holding the CPU
// while a session is in progress.
//
// Parameters:
//   MEMORY_SIZE  instruction memory depth in 32-bit words
//   CW           word-count width; 2**CW must exceed MEMORY_SIZE and CW+2 <= 32
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   start         one-cycle session request (honoured in IDLE or DONE only)
//   num_words     words to load, sampled on an accepted start
//   abort         synchronous cancel; takes priority over start
//   byte_valid    byte_data carries a stream byte
//   byte_data     stream byte
//   byte_ready    loader accepts a byte this cycle
//   mem_we        one-cycle memory write strobe
//   mem_addr      word-aligned byte address of the write
//   mem_wdata     write data
//   busy          session in progress
//   cpu_hold      hold PC/fetch while memory is rewritten
//   done          last session completed
//   error         last start rejected (num_words > MEMORY_SIZE)
module imem_loader #(
    parameter int unsigned MEMORY_SIZE = 32,
    parameter int unsigned CW          = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] num_words,
    input  logic          abort,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          busy,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);

    typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

    state_e        state_q;
    logic [1:0]    byte_idx_q;
    logic [CW-1:0] word_idx_q;
    logic [CW-1:0] num_words_q;
    // Only the first three bytes need buffering; the fourth goes straight to mem_wdata.
    logic [23:0]   word_buf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            byte_idx_q  <= 2'd0;
            word_idx_q  <= '0;
            num_words_q <= '0;
            word_buf_q  <= 24'h0;
            byte_ready  <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wdata   <= 32'h0;
            busy        <= 1'b0;
            cpu_hold    <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start && !abort) begin
                        done        <= 1'b0;
                        error       <= 1'b0;
                        byte_idx_q  <= 2'd0;
                        word_idx_q  <= '0;
                        num_words_q <= num_words;
                        if (num_words == '0) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else if (32'(num_words) > MEMORY_SIZE) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                            error   <= 1'b1;
                        end else begin
                            state_q    <= StLoad;
                            byte_ready <= 1'b1;
                            busy       <= 1'b1;
                            cpu_hold   <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    if (abort) begin
                        // Partial word is dropped; done stays low.
                        state_q    <= StIdle;
                        byte_idx_q <= 2'd0;
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        cpu_hold   <= 1'b0;
                    end else if (byte_valid && byte_ready) begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        unique case (byte_idx_q)
                            2'd0: word_buf_q[7:0]   <= byte_data;
                            2'd1: word_buf_q[15:8]  <= byte_data;
                            2'd2: word_buf_q[23:16] <= byte_data;
                            default: begin
                                state_q    <= StWrite;
                                byte_ready <= 1'b0;
                                mem_we     <= 1'b1;
                                mem_wdata  <= {byte_data, word_buf_q};
                                mem_addr   <= 32'({word_idx_q, 2'b00});
                            end
                        endcase
                    end
                end
                StWrite: begin
                    // The write itself is already on the bus this cycle; abort only
                    // decides where we go next.
                    byte_idx_q <= 2'd0;
                    if (abort) begin
                        state_q  <= StIdle;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                    end else if (word_idx_q + CW'(1) == num_words_q) begin
                        state_q  <= StDone;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                    end else begin
                        state_q    <= StLoad;
                        word_idx_q <= word_idx_q + CW'(1);
                        byte_ready <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a reference model queues the expected
// (address, data) of every write; a monitor pops and compares on each mem_we.
module tb_imem_loader;

    localparam int MS = 32;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] num_words = '0;
    logic          abort = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h0;
    logic          byte_ready, mem_we, busy, cpu_hold, done, error;
    logic [31:0]   mem_addr, mem_wdata;

    imem_loader #(.MEMORY_SIZE(MS), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_words (num_words),
        .abort     (abort),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          fails = 0;
    int          we_count = 0;
    logic [31:0] last_addr = 32'h0;
    logic        prev_we = 1'b0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            chkb("no_we_in_reset", mem_we, 1'b0);
        end else if (mem_we) begin
            we_count++;
            last_addr = mem_addr;
            chkb("ready_low_in_write", byte_ready, 1'b0);
            chkb("we_one_cycle", prev_we, 1'b0);
            if (exp_addr.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected none",
                         mem_addr, mem_wdata);
            end else begin
                chk("wr_addr", mem_addr, exp_addr.pop_front());
                chk("wr_data", mem_wdata, exp_data.pop_front());
            end
        end
        prev_we = mem_we;
    end

    // Model: word w of a session lands at byte address 4*w, bytes little-endian.
    function automatic logic [31:0] le_word(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
        int unsigned v;
        v = int'(b0) + int'(b1) * 256 + int'(b2) * 65536 + int'(b3) * 16777216;
        return v;
    endfunction

    task automatic do_start(input int n);
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b1;
        num_words  = CW'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte after an optional idle gap; returns just after the
    // rising edge that accepted it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chkb("byte_ready_timeout", byte_ready, 1'b1);
        @(posedge clk);
    endtask

    task automatic run_words(input int n, input int gap_max);
        logic [7:0] b[4];
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
            exp_addr.push_back(32'(4 * w));
            exp_data.push_back(le_word(b[0], b[1], b[2], b[3]));
            for (int k = 0; k < 4; k++) send_byte(b[k], int'($urandom_range(0, gap_max)));
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chkb(name, done, 1'b1);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_out"}, {24'h0, byte_ready, mem_we, busy, cpu_hold, done, error, 2'b0}, 32'h0);
        chk({name, "_addr"}, mem_addr, 32'h0);
        chk({name, "_wdata"}, mem_wdata, 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] bs[8];

        // Reset state
        #1 chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("post_reset");

        // Single word 13,05,50,00
        base = we_count;
        do_start(1);
        chk("load_flags", {29'h0, busy, cpu_hold, byte_ready}, 32'h7);
        exp_addr.push_back(32'h0);
        exp_data.push_back(32'h0050_0513);
        send_byte(8'h13, 0);
        send_byte(8'h05, 0);
        send_byte(8'h50, 0);
        send_byte(8'h00, 0);
        #1;
        chkb("we_latency", mem_we, 1'b1);
        @(negedge clk);
        byte_valid = 1'b0;
        wait_done("single_done");
        chkb("single_hold", cpu_hold, 1'b0);
        chkb("single_err", error, 1'b0);
        chk("single_count", 32'(we_count - base), 32'd1);

        // Three words with random gaps
        base = we_count;
        do_start(3);
        run_words(3, 3);
        wait_done("three_done");
        chk("three_count", 32'(we_count - base), 32'd3);
        chk("three_last_addr", last_addr, 32'd8);

        // num_words = 0 and 33
        base = we_count;
        do_start(0);
        wait_done("zero_done");
        chkb("zero_err", error, 1'b0);
        do_start(MS + 1);
        wait_done("over_done");
        chkb("over_err", error, 1'b1);
        chkb("over_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        chk("no_write_count", 32'(we_count - base), 32'd0);

        // Full memory
        base = we_count;
        do_start(MS);
        run_words(MS, 0);
        wait_done("full_done");
        chk("full_count", 32'(we_count - base), 32'(MS));
        chk("full_last_addr", last_addr, 32'd124);

        // Abort after 2 bytes of word 1
        base = we_count;
        do_start(2);
        run_words(1, 1);
        send_byte(8'($urandom), 0);
        send_byte(8'($urandom), 1);
        @(negedge clk);
        byte_valid = 1'b0;
        abort      = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_flags", {28'h0, busy, cpu_hold, byte_ready, done}, 32'h0);
        repeat (4) @(negedge clk);
        chk("abort_count", 32'(we_count - base), 32'd1);
        chk("abort_pending", 32'(exp_addr.size()), 32'd0);
        do_start(1);
        run_words(1, 0);
        wait_done("restart_done");
        chk("restart_addr", last_addr, 32'd0);

        // Start during LOAD is ignored
        base = we_count;
        for (int i = 0; i < 8; i++) bs[i] = 8'($urandom);
        do_start(2);
        exp_addr.push_back(32'd0);
        exp_data.push_back(le_word(bs[0], bs[1], bs[2], bs[3]));
        exp_addr.push_back(32'd4);
        exp_data.push_back(le_word(bs[4], bs[5], bs[6], bs[7]));
        send_byte(bs[0], 0);
        do_start(5);
        for (int i = 1; i < 8; i++) send_byte(bs[i], int'($urandom_range(0, 2)));
        @(negedge clk);
        byte_valid = 1'b0;
        wait_done("ignore_done");
        chk("ignore_count", 32'(we_count - base), 32'd2);

        // Random sessions
        for (int r = 0; r < 4; r++) begin
            int n;
            n = int'($urandom_range(1, 5));
            base = we_count;
            do_start(n);
            run_words(n, 2);
            wait_done("rand_done");
            chk("rand_count", 32'(we_count - base), 32'(n));
        end

        // Reset mid-LOAD
        base = we_count;
        do_start(2);
        send_byte(8'($urandom), 0);
        send_byte(8'($urandom), 0);
        @(negedge clk);
        byte_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_count", 32'(we_count - base), 32'd0);
        do_start(1);
        run_words(1, 0);
        wait_done("after_reset_done");
        chk("after_reset_addr", last_addr, 32'd0);
        chk("final_pending", 32'(exp_addr.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
